// File: rtl/reg_writeback.sv
// Register-file writeback stage: arbitrates the ALU and load channels into a 4-entry pending-write queue.
// Define WB_BYPASS_EN to send an entry straight to the write port when the queue is empty.
module reg_writeback (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_dest,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_dest,
  input  logic [31:0] mem_data,
  output logic        regWrite,
  output logic [4:0]  regD,
  output logic [31:0] writeData,
  output logic [15:0] busy,
  output logic        fifo_full,
  output logic        fifo_empty
);

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
  } entry_t;

  entry_t      fifo_q [4];
  logic [2:0]  count_q, count_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic        regwrite_q, regwrite_d;
  logic [4:0]  regd_q, regd_d;
  logic [31:0] wdata_q, wdata_d;

  logic   push, pop, bypass, enqueue;
  entry_t in_entry, head;

  // Only architectural registers 1..15 are written; R0 and 16..31 are dropped.
  function automatic logic writable(input logic [4:0] dest);
    return (dest[4] == 1'b0) && (dest != 5'd0);
  endfunction

  assign mem_ready  = !reset && (count_q < 3'd4);
  assign alu_ready  = mem_ready && !mem_valid;
  assign fifo_full  = !reset && (count_q == 3'd4);
  assign fifo_empty = reset || (count_q == 3'd0);

  assign push     = (mem_valid && mem_ready) || (alu_valid && alu_ready);
  assign in_entry = mem_valid ? entry_t'{mem_dest, mem_data} : entry_t'{alu_dest, alu_data};
  assign pop      = (count_q != 3'd0);
  assign head     = fifo_q[rd_ptr_q];

`ifdef WB_BYPASS_EN
  assign bypass = push && (count_q == 3'd0);
`else
  assign bypass = 1'b0;
`endif
  assign enqueue = push && !bypass;

  always_comb begin
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    regwrite_d = 1'b0;
    regd_d     = regd_q;
    wdata_d    = wdata_q;
    if (pop) begin
      regd_d     = head.dest;
      wdata_d    = head.data;
      regwrite_d = writable(head.dest);
      rd_ptr_d   = rd_ptr_q + 2'd1;
    end
    if (bypass) begin
      regd_d     = in_entry.dest;
      wdata_d    = in_entry.data;
      regwrite_d = writable(in_entry.dest);
    end
    if (enqueue) wr_ptr_d = wr_ptr_q + 2'd1;
    count_d = count_q + {2'b00, enqueue} - {2'b00, pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= 3'd0;
      rd_ptr_q   <= 2'd0;
      wr_ptr_q   <= 2'd0;
      regwrite_q <= 1'b0;
      regd_q     <= 5'd0;
      wdata_q    <= 32'd0;
    end else begin
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      regwrite_q <= regwrite_d;
      regd_q     <= regd_d;
      wdata_q    <= wdata_d;
    end
  end

  // NOTE: queue storage is not reset; count gates every read, so stale contents are never used.
  always_ff @(posedge clk) begin
    if (enqueue) fifo_q[wr_ptr_q] <= in_entry;
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < 4; i++) begin
      if ((3'(i) < count_q) && writable(fifo_q[rd_ptr_q + 2'(i)].dest))
        busy[fifo_q[rd_ptr_q + 2'(i)].dest[3:0]] = 1'b1;
    end
    if (regwrite_q) busy[regd_q[3:0]] = 1'b1;
    if (reset) busy = '0;
  end

  assign regWrite  = regwrite_q;
  assign regD      = regd_q;
  assign writeData = wdata_q;

endmodule
